// File: rtl/if_stage_pc_ifid.sv
// Instruction fetch stage: owns the program counter feeding InstructionMemory and
// registers the fetched word plus PC+4 into the IF/ID pipeline register.
module if_stage_pc_ifid #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc_out,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      pc_plus4;
    logic [31:0]      instr_reg, instr_next;
    logic [31:0]      pc4_reg, pc4_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             redirect;
    logic             squash;

    assign pc_plus4 = pc_reg + 32'd4;
    assign redirect = branch_taken | jump;
    // A redirect also squashes the wrong-path word being fetched this cycle.
    assign squash   = flush | redirect;

    always_comb begin
        pc_next = pc_plus4;
        if (branch_taken) begin
            pc_next = branch_target & ALIGN_MASK;
        end else if (jump) begin
            pc_next = jump_target & ALIGN_MASK;
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_comb begin
        instr_next = instr_reg;
        pc4_next   = pc4_reg;
        valid_next = valid_reg;
        count_next = count_reg;
        if (squash) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (!stall) begin
            instr_next = instr_in;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
            count_next = count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_INSTR;
            pc4_reg   <= 32'h0000_0000;
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pc4_reg   <= pc4_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    assign pc_out         = pc_reg;
    assign if_id_instr    = instr_reg;
    assign if_id_pc_plus4 = pc4_reg;
    assign if_id_valid    = valid_reg;
    assign fetch_count    = count_reg;

endmodule

// File: doc/if_stage_pc_ifid.md
Name: if_stage_pc_ifid

Overview:
- Fetch stage wrapped around `InstructionMemory`: owns the program counter that drives the memory's `pc_out` input.
- Registers the returned `output_instr` together with PC+4 into the IF/ID pipeline register for the decode stage.
- Handles hazard stalls, branch/jump redirects and flushes, and keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on reset or flush (MIPS sll $0,$0,0).
- CNT_W, 32, width of fetch counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush  in  1  control: squash IF/ID (load NOP, valid=0)
- branch_taken  in  1  redirect to branch_target next cycle
- branch_target  in  32  branch destination address
- jump  in  1  redirect to jump_target next cycle
- jump_target  in  32  jump destination address
- instr_in  in  32  `output_instr` from InstructionMemory
- pc_out  out  32  current fetch address to InstructionMemory
- if_id_instr  out  32  registered instruction to decode
- if_id_pc_plus4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  CNT_W  number of instructions accepted into IF/ID

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is synchronous and active-low: sampled only on rising clk edge; while low, all state is reset.
- Reset values:
  - pc_out = RESET_PC
  - if_id_instr = NOP_INSTR
  - if_id_pc_plus4 = 0
  - if_id_valid = 0
  - fetch_count = 0
- Instruction memory timing: InstructionMemory read is combinational from pc_out. instr_in is valid in the same cycle pc_out is presented.
- Next-PC selection at each edge (rst_n high), in priority order:
  1. branch_taken → {branch_target[31:2],2'b00}
  2. else jump → {jump_target[31:2],2'b00}
  3. else stall → hold pc_out
  4. else pc_out+4
- Next-PC rules:
  - Redirect overrides stall; the stalled instruction is by definition squashed by the redirect.
  - branch_taken has priority over jump when both are asserted.
  - Targets are force-aligned: low 2 bits dropped, no error flagged.
  - PC+4 arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- IF/ID update at each edge (rst_n high), in priority order:
  1. flush or branch_taken or jump → if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc_plus4 unchanged
  2. else stall → all IF/ID outputs hold
  3. else if_id_instr=instr_in, if_id_pc_plus4=pc_out+4, if_id_valid=1
- IF/ID notes:
  - A redirect implicitly flushes the wrong-path instruction currently being fetched.
  - flush with stall: flush wins.
- Latency: instruction at address A (pc_out=A during cycle n) appears on if_id_instr in cycle n+1 with if_id_pc_plus4=A+4.
- Throughput: one fetch per cycle when unstalled.
- fetch_count:
  - Increments by 1 on every edge where IF/ID loads with if_id_valid=1 (IF/ID case 3).
  - Wraps modulo 2^CNT_W, no saturation.
- Reset mid-operation: pending stall/redirect inputs in the reset cycle are ignored; first post-reset fetch is RESET_PC.
- Invariant: outputs change only on rising clk edge; no combinational path from inputs to outputs.

Test Plan:
- Reset/sequential fetch: rst_n low 2 cycles then high, no control → pc_out 0,4,8,12,16 on successive cycles. if_id_pc_plus4 = 4,8,12,16 one cycle behind, if_id_valid=1 from first post-reset edge. fetch_count=4 after 4 edges.
- Stall: assert stall one cycle with pc_out=8 → pc_out stays 8, if_id_instr/if_id_pc_plus4 (=8) hold, fetch_count not incremented. Release → pc_out=12.
- Branch redirect: at pc_out=12 assert branch_taken, branch_target=32'h40 → next cycle pc_out=0x40, if_id_instr=NOP_INSTR, if_id_valid=0. Following cycle if_id_pc_plus4=0x44, valid=1.
- Priority/alignment: branch_taken+jump+stall together, branch_target=0x103, jump_target=0x200 → pc_out=0x100, IF/ID squashed.
- Flush vs stall: flush and stall together → if_id_valid=0, if_id_instr=NOP_INSTR, pc_out held.
- Wrap and mid-run reset: jump to 0xFFFF_FFFC then free-run → pc_out=0x0, if_id_pc_plus4=0x0. Then drop rst_n with stall=1 → pc_out=RESET_PC, fetch_count=0.
